// File: rtl/search_scheduler_if.sv
// search_scheduler_if: front-end and worker-pool signals of the search scheduler.
// master drives control and worker status; slave (the scheduler) drives grants and results.
interface search_scheduler_if #(
  parameter int WORKERS = 4
);
  logic                   start;
  logic                   abort;
  logic [31:0]            limit;
  logic [WORKERS-1:0]     work_req;
  logic [WORKERS-1:0]     chunk_done;
  logic [WORKERS-1:0]     hit_valid;
  logic [32*WORKERS-1:0]  hit_counter;
  logic [WORKERS-1:0]     work_grant;
  logic [31:0]            work_base;
  logic [31:0]            work_len;
  logic                   worker_stop;
  logic                   busy;
  logic                   found;
  logic                   exhausted;
  logic [31:0]            result;
  logic [31:0]            chunks_issued;

  modport master (
    output start, abort, limit,
    output work_req, chunk_done,
    output hit_valid, hit_counter,
    input  work_grant, work_base, work_len,
    input  worker_stop, busy, found,
    input  exhausted, result, chunks_issued
  );

  modport slave (
    input  start, abort, limit,
    input  work_req, chunk_done,
    input  hit_valid, hit_counter,
    output work_grant, work_base, work_len,
    output worker_stop, busy, found,
    output exhausted, result, chunks_issued
  );
endinterface

// File: rtl/search_scheduler.sv
// search_scheduler: hands fixed-size chunks of 0..limit to searcher workers round-robin.
// Ports: clk, reset (async, active low), bus (slave side of search_scheduler_if).
// Optional grant statistics counter: define SEARCH_SCHEDULER_STATS_EN.
module search_scheduler #(
  parameter int          WORKERS = 4,
  parameter logic [31:0] CHUNK   = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              reset,
  search_scheduler_if.slave bus
);
  localparam int PW = (WORKERS > 1) ? $clog2(WORKERS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [31:0]        next_base_q;
  logic [31:0]        limit_q;
  logic               range_done_q;
  logic [WORKERS-1:0] held_q;
  logic [WORKERS-1:0] grant_q;
  logic [PW-1:0]      ptr_q;
  logic [31:0]        base_q;
  logic [31:0]        len_q;
  logic [31:0]        result_q;
  logic               found_q;
  logic               exh_q;
  logic               stop_q;
  logic               busy_q;
`ifdef SEARCH_SCHEDULER_STATS_EN
  logic [31:0]        cnt_q;
`endif

  logic [WORKERS-1:0] elig;
  logic [WORKERS-1:0] gnt_oh;
  logic [WORKERS-1:0] held_d;
  logic               gnt_v;
  logic [PW-1:0]      ptr_d;
  int                 idx;
  logic               hit_v;
  logic [31:0]        hit_cnt;
  logic [32:0]        remain;
  logic [32:0]        sum;
  logic [31:0]        len_d;
  logic               rd_d;

  // Round-robin pick starting at ptr_q.
  always_comb begin
    elig   = bus.work_req & ~held_q & {WORKERS{~range_done_q}};
    gnt_oh = '0;
    gnt_v  = 1'b0;
    ptr_d  = ptr_q;
    idx    = 0;
    for (int k = 0; k < WORKERS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= WORKERS) idx = idx - WORKERS;
      if (!gnt_v && elig[idx]) begin
        gnt_v       = 1'b1;
        gnt_oh[idx] = 1'b1;
        ptr_d       = (idx == WORKERS - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  // Lowest-index hit wins.
  always_comb begin
    hit_v   = |bus.hit_valid;
    hit_cnt = '0;
    for (int i = WORKERS - 1; i >= 0; i--) begin
      if (bus.hit_valid[i]) hit_cnt = bus.hit_counter[32*i +: 32];
    end
  end

  // 33-bit math so limit=FFFFFFFF and carry-out behave.
  always_comb begin
    held_d = (held_q & ~bus.chunk_done) | gnt_oh;
    remain = {1'b0, limit_q} - {1'b0, next_base_q} + 33'd1;
    len_d  = (remain > {1'b0, CHUNK}) ? CHUNK : remain[31:0];
    sum    = {1'b0, next_base_q} + {1'b0, CHUNK};
    rd_d   = (sum > {1'b0, limit_q});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      next_base_q  <= '0;
      limit_q      <= '0;
      range_done_q <= 1'b0;
      held_q       <= '0;
      grant_q      <= '0;
      ptr_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      result_q     <= '0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
      stop_q       <= 1'b1;
      busy_q       <= 1'b0;
`ifdef SEARCH_SCHEDULER_STATS_EN
      cnt_q        <= '0;
`endif
    end else begin
      grant_q <= '0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q      <= RUN;
            next_base_q  <= '0;
            range_done_q <= 1'b0;
            held_q       <= '0;
            limit_q      <= bus.limit;
            found_q      <= 1'b0;
            exh_q        <= 1'b0;
            result_q     <= '0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b1;
`ifdef SEARCH_SCHEDULER_STATS_EN
            cnt_q        <= '0;
`endif
          end
        end
        RUN: begin
          if (hit_v) begin
            state_q  <= DONE;
            result_q <= hit_cnt;
            found_q  <= 1'b1;
            stop_q   <= 1'b1;
            busy_q   <= 1'b0;
          end else if (bus.abort) begin
            state_q <= DONE;
            stop_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (range_done_q && held_q == '0) begin
            state_q <= DONE;
            exh_q   <= 1'b1;
            stop_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            held_q <= held_d;
            if (gnt_v) begin
              grant_q     <= gnt_oh;
              base_q      <= next_base_q;
              len_q       <= len_d;
              next_base_q <= sum[31:0];
              ptr_q       <= ptr_d;
              if (rd_d) range_done_q <= 1'b1;
`ifdef SEARCH_SCHEDULER_STATS_EN
              if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.work_grant  = grant_q;
  assign bus.work_base   = base_q;
  assign bus.work_len    = len_q;
  assign bus.worker_stop = stop_q;
  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.exhausted   = exh_q;
  assign bus.result      = result_q;
`ifdef SEARCH_SCHEDULER_STATS_EN
  assign bus.chunks_issued = cnt_q;
`else
  assign bus.chunks_issued = 32'd0;
`endif
endmodule

// File: tb/tb_search_scheduler.sv
// tb_search_scheduler: vector table, directed corner sequences and random traffic
// checked against a behavioural model of the chunk scheduler.
module tb_search_scheduler;
  localparam int          W   = 4;
  localparam logic [31:0] CH  = 32'd16;
  localparam logic [31:0] WCH = 32'h8000_0000;
`ifdef SEARCH_SCHEDULER_STATS_EN
  localparam logic [31:0] SMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SMASK = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  search_scheduler_if #(.WORKERS(W)) bus ();
  search_scheduler_if #(.WORKERS(W)) bw ();

  search_scheduler #(.WORKERS(W), .CHUNK(CH)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  search_scheduler #(.WORKERS(W), .CHUNK(WCH)) dutw (
    .clk(clk), .reset(reset), .bus(bw));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference for dut.
  bit          m_run = 1'b0;
  longint      m_next = 0;
  longint      m_lim = 0;
  longint      m_rem;
  bit          m_rd = 1'b0;
  bit          m_held [W];
  int          m_ptr = 0;
  int          m_hw, m_g, m_i;
  bit          m_any;
  logic [W-1:0] e_grant = '0;
  logic [31:0] e_base = '0, e_len = '0, e_res = '0, e_cnt = '0;
  bit          e_found = 1'b0, e_exh = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_ptr = 0; m_next = 0; m_rd = 0;
      foreach (m_held[i]) m_held[i] = 0;
      e_grant = '0; e_base = '0; e_len = '0;
      e_res = '0; e_cnt = '0; e_found = 0; e_exh = 0;
    end else begin
      e_grant = '0;
      if (!m_run) begin
        if (bus.start) begin
          m_run = 1; m_next = 0; m_rd = 0;
          foreach (m_held[i]) m_held[i] = 0;
          e_found = 0; e_exh = 0; e_res = '0; e_cnt = '0;
          m_lim = longint'(bus.limit);
        end
      end else begin
        m_hw = -1;
        for (int i = W - 1; i >= 0; i--)
          if (bus.hit_valid[i]) m_hw = i;
        m_any = 0;
        foreach (m_held[i]) if (m_held[i]) m_any = 1;
        if (m_hw >= 0) begin
          e_res = bus.hit_counter[32*m_hw +: 32];
          e_found = 1; m_run = 0;
        end else if (bus.abort) begin
          m_run = 0;
        end else if (m_rd && !m_any) begin
          e_exh = 1; m_run = 0;
        end else begin
          m_g = -1;
          for (int k = 0; k < W; k++) begin
            m_i = (m_ptr + k) % W;
            if (m_g < 0 && bus.work_req[m_i] && !m_held[m_i] && !m_rd)
              m_g = m_i;
          end
          for (int i = 0; i < W; i++)
            if (bus.chunk_done[i]) m_held[i] = 0;
          if (m_g >= 0) begin
            e_grant[m_g] = 1'b1;
            e_base = 32'(m_next);
            m_rem = m_lim - m_next + 1;
            e_len = (m_rem > longint'(CH)) ? CH : 32'(m_rem);
            m_held[m_g] = 1;
            m_next = m_next + longint'(CH);
            if (m_next > m_lim) m_rd = 1;
            m_ptr = (m_g + 1) % W;
            if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + (32'd1 & SMASK);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_grant", 32'(bus.work_grant), 32'(e_grant));
    chk("m_base", bus.work_base, e_base);
    chk("m_len", bus.work_len, e_len);
    chk("m_busy", 32'(bus.busy), 32'(m_run));
    chk("m_stop", 32'(bus.worker_stop), 32'(!m_run));
    chk("m_found", 32'(bus.found), 32'(e_found));
    chk("m_exh", 32'(bus.exhausted), 32'(e_exh));
    chk("m_result", bus.result, e_res);
    chk("m_chunks", bus.chunks_issued, e_cnt);
  end

  typedef struct {
    logic        st;
    logic [3:0]  req;
    logic [3:0]  dn;
    logic [3:0]  eg;
    logic [31:0] eb;
    logic [31:0] el;
    logic        ebusy;
    logic        eexh;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tab [8];
    tab[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 32'd0,  32'd0,  1'b1, 1'b0};
    tab[1] = '{1'b0, 4'hF, 4'h0, 4'h1, 32'd0,  32'd16, 1'b1, 1'b0};
    tab[2] = '{1'b0, 4'hE, 4'h0, 4'h2, 32'd16, 32'd16, 1'b1, 1'b0};
    tab[3] = '{1'b0, 4'hC, 4'h0, 4'h4, 32'd32, 32'd16, 1'b1, 1'b0};
    tab[4] = '{1'b0, 4'h8, 4'h0, 4'h8, 32'd48, 32'd16, 1'b1, 1'b0};
    tab[5] = '{1'b0, 4'h0, 4'hF, 4'h0, 32'd0,  32'd0,  1'b1, 1'b0};
    tab[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'd0,  32'd0,  1'b0, 1'b1};
    tab[7] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'd0,  32'd0,  1'b0, 1'b1};

    bus.start = 0; bus.abort = 0; bus.limit = 0;
    bus.work_req = 0; bus.chunk_done = 0;
    bus.hit_valid = 0; bus.hit_counter = '0;
    bw.start = 0; bw.abort = 0; bw.limit = 0;
    bw.work_req = 0; bw.chunk_done = 0;
    bw.hit_valid = 0; bw.hit_counter = '0;

    tick(); tick();
    chk("rst_grant", 32'(bus.work_grant), 32'd0);
    chk("rst_stop", 32'(bus.worker_stop), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    reset = 1;

    // Exhaustion over 0..63.
    bus.limit = 32'd63;
    for (int i = 0; i < 8; i++) begin
      bus.start = tab[i].st;
      bus.work_req = tab[i].req;
      bus.chunk_done = tab[i].dn;
      tick();
      chk($sformatf("tab%0d_grant", i), 32'(bus.work_grant), 32'(tab[i].eg));
      if (tab[i].eg != 4'h0) begin
        chk($sformatf("tab%0d_base", i), bus.work_base, tab[i].eb);
        chk($sformatf("tab%0d_len", i), bus.work_len, tab[i].el);
      end
      chk($sformatf("tab%0d_busy", i), 32'(bus.busy), 32'(tab[i].ebusy));
      chk($sformatf("tab%0d_exh", i), 32'(bus.exhausted), 32'(tab[i].eexh));
    end
    chk("exh_found", 32'(bus.found), 32'd0);
    chk("exh_chunks", bus.chunks_issued, 32'd4 & SMASK);

    // Short tail: limit 40.
    bus.limit = 32'd40; bus.start = 1; tick(); bus.start = 0;
    bus.work_req = 4'hF; tick();
    chk("tail_g0", 32'(bus.work_grant), 32'h1);
    bus.work_req = 4'hE; tick();
    chk("tail_g1", 32'(bus.work_grant), 32'h2);
    bus.work_req = 4'hC; tick();
    chk("tail_g2", 32'(bus.work_grant), 32'h4);
    chk("tail_base", bus.work_base, 32'd32);
    chk("tail_len", bus.work_len, 32'd9);
    bus.work_req = 4'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tail_nogrant", 32'(bus.work_grant), 32'd0);
    end
    bus.chunk_done = 4'h7; tick(); bus.chunk_done = 0;
    chk("tail_notyet", 32'(bus.exhausted), 32'd0);
    tick();
    chk("tail_exh", 32'(bus.exhausted), 32'd1);
    bus.work_req = 0;

    // Two hits on one cycle.
    bus.limit = 32'd1000; bus.start = 1; tick(); bus.start = 0;
    bus.hit_valid = 4'hA;
    bus.hit_counter = {32'h37, 32'h0, 32'h15, 32'h0};
    tick();
    bus.hit_valid = 0;
    chk("hit_found", 32'(bus.found), 32'd1);
    chk("hit_result", bus.result, 32'h15);
    chk("hit_stop", 32'(bus.worker_stop), 32'd1);

    // Abort with simultaneous hit, then plain abort.
    bus.start = 1; tick(); bus.start = 0;
    bus.abort = 1; bus.hit_valid = 4'h4;
    bus.hit_counter = {32'h0, 32'h99, 64'h0};
    tick();
    bus.abort = 0; bus.hit_valid = 0;
    chk("abhit_found", 32'(bus.found), 32'd1);
    chk("abhit_result", bus.result, 32'h99);
    bus.start = 1; tick(); bus.start = 0;
    chk("ab_cleared", 32'(bus.found), 32'd0);
    bus.abort = 1; tick(); bus.abort = 0;
    chk("ab_found", 32'(bus.found), 32'd0);
    chk("ab_exh", 32'(bus.exhausted), 32'd0);
    chk("ab_stop", 32'(bus.worker_stop), 32'd1);

    // Carry-out at the top of the 32-bit space (second instance).
    bw.limit = 32'hFFFF_FFFF; bw.start = 1; tick(); bw.start = 0;
    bw.work_req = 4'hF; tick();
    chk("wrap_g0", 32'(bw.work_grant), 32'h1);
    chk("wrap_len0", bw.work_len, WCH);
    bw.work_req = 4'hE; tick();
    chk("wrap_g1", 32'(bw.work_grant), 32'h2);
    chk("wrap_base1", bw.work_base, 32'h8000_0000);
    chk("wrap_len1", bw.work_len, WCH);
    bw.work_req = 4'hC;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wrap_nogrant", 32'(bw.work_grant), 32'd0);
    end
    bw.chunk_done = 4'h3; tick(); bw.chunk_done = 0; tick();
    chk("wrap_exh", 32'(bw.exhausted), 32'd1);
    bw.work_req = 0;

    // Asynchronous reset mid-run.
    bus.limit = 32'd100; bus.start = 1; tick(); bus.start = 0;
    bus.work_req = 4'hF; tick();
    bus.work_req = 4'h7; tick();
    chk("pre_rst_base", bus.work_base, 32'd16);
    bus.work_req = 0;
    #2 reset = 0;
    #1;
    chk("arst_grant", 32'(bus.work_grant), 32'd0);
    chk("arst_base", bus.work_base, 32'd0);
    chk("arst_len", bus.work_len, 32'd0);
    chk("arst_stop", 32'(bus.worker_stop), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_chunks", bus.chunks_issued, 32'd0);
    tick(); tick();
    reset = 1;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_stop", 32'(bus.worker_stop), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.limit = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF
                                               : 32'($urandom_range(0, 120));
      bus.abort = ($urandom_range(0, 59) == 0);
      bus.work_req = 4'($urandom);
      bus.chunk_done = 4'($urandom) & 4'($urandom);
      bus.hit_valid = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'h0;
      bus.hit_counter = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/search_scheduler.md
# search_scheduler

Work scheduler for the SHA-1 collision search datapath. It splits the counter space `0..limit` into fixed-size chunks and hands them to a pool of searcher workers over a request/grant handshake, using round-robin arbitration. It captures the first collision reported and stops all workers on that hit, on abort, or when the space is exhausted. It sits between the custom-instruction front end and the searcher array, replacing the fixed interleaved counter/increment assignment with on-demand dispatch.

## Interface
Parameters:
- `WORKERS`, 4: number of searcher workers (2..32).
- `CHUNK`, 32'h0001_0000: counter values per chunk; must be nonzero.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a search.
- `abort` in 1: one-cycle pulse; ends the current search without a result.
- `limit` in 32: last counter value searched (inclusive); sampled on accepted `start`.
- `work_req` in WORKERS: worker i requests a chunk; level, held until granted.
- `chunk_done` in WORKERS: pulse; worker i finished its chunk with no hit.
- `hit_valid` in WORKERS: pulse; worker i found a collision.
- `hit_counter` in 32*WORKERS: counter of worker i's hit, in bits [32i+31:32i].
- `work_grant` out WORKERS: one-hot one-cycle grant.
- `work_base` out 32: first counter of the granted chunk; valid with grant.
- `work_len` out 32: number of counters in the granted chunk; valid with grant.
- `worker_stop` out 1: high means workers must abandon their chunks.
- `busy` out 1: search in progress.
- `found` out 1: last search ended with a hit.
- `exhausted` out 1: last search covered `0..limit` with no hit.
- `result` out 32: hit counter, valid when `found` is high.
- `chunks_issued` out 32: statistics counter (see Configuration).

## Operation
- The controller has three states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE → RUN on `start`. On entry:
  - `next_base=0`, `range_done=0`, all `held` bits cleared.
  - `found`, `exhausted`, `result` and `chunks_issued` cleared.
  - `limit` latched.
- `start` is ignored while in RUN.
- Dispatch in RUN:
  - Eligible requesters are those with `work_req[i]` set, `held[i]` clear and `range_done` clear.
  - Round-robin selection begins at the index after the last granted worker; the pointer resets to 0 on `reset`.
  - A grant outputs `work_base=next_base` and `work_len=min(CHUNK, limit-next_base+1)`. This is computed in 33 bits, so `limit=FFFFFFFF` with base 0 yields a `work_len` of at most CHUNK.
  - A grant sets `held[i]` and sets `next_base=next_base+CHUNK` in 33 bits. If the sum is greater than `limit` or carries out of bit 32, `range_done` is set.
  - At most one grant per cycle.
- `chunk_done[i]` clears `held[i]`. `chunk_done` on a worker without `held` set is ignored.
- Hits in RUN:
  - The lowest index with `hit_valid` wins.
  - `result` is set to that worker's counter, `found` is set to 1, and the state goes to DONE.
  - If `hit_valid[i]` and `chunk_done[i]` occur on the same cycle, the hit wins.
- Exhaustion: in RUN with `range_done=1`, no `held` bit set and no hit → `exhausted` set to 1, state goes to DONE.
- `abort` in RUN → DONE with `found=0` and `exhausted=0`. If a hit arrives on the same cycle, the hit wins.
- `hit_valid`, `chunk_done` and `work_req` are ignored in IDLE and DONE.
- `worker_stop` is high in IDLE and DONE and low in RUN. `busy` is the inverse of `worker_stop`.
- Reset mid-search: all outputs go to reset values immediately (asynchronous) and the state goes to IDLE.

## Timing
- Reset values:
  - `work_grant=0`, `work_base=0`, `work_len=0`.
  - `worker_stop=1`, `busy=0`.
  - `found=0`, `exhausted=0`, `result=0`, `chunks_issued=0`.
- All outputs are registered.
- `start` sampled at edge N → `busy=1` and `worker_stop=0` after edge N. Requests are eligible from edge N+1.
- Request visible at edge M → `work_grant`, `work_base` and `work_len` are high/valid for exactly the cycle after edge M.
- Workers drop `work_req` in the grant cycle. A request still high in that cycle is not regranted while `held` is set.
- Hit, abort or exhaustion detected at edge K → `found`/`exhausted`/`result` and `worker_stop=1` valid after edge K. No grant is issued on that edge.
- Throughput: one chunk per cycle with continuous requests.

## Configuration
- `SEARCH_SCHEDULER_STATS_EN` defined: `chunks_issued` increments on every grant, saturates at FFFFFFFF, and clears on accepted `start`.
- Macro undefined: the counter is not built and `chunks_issued` is constant 0.

## Test plan
All scenarios use `WORKERS=4`, `CHUNK=16`.
- Reset: assert `reset`=0 mid-RUN → all outputs take their reset values at once; after release, `busy=0` and `worker_stop=1`.
- Exhaustion: `limit=63`, `start`, all 4 `work_req` held → grants to workers 0,1,2,3 on consecutive cycles with bases 0,16,32,48 and `work_len=16`. All 4 `chunk_done` → `exhausted=1`, `found=0`, `chunks_issued=4` (STATS_EN).
- Short tail: `limit=40` → third grant has base 32, `work_len=9`. The fourth request is never granted. `exhausted=1` after 3 `chunk_done`.
- Simultaneous hits: workers 1 and 3 assert `hit_valid` with counters 0x15 and 0x37 on the same cycle → `result=0x15`, `found=1`, `worker_stop=1` next cycle.
- Wrap: `limit=FFFFFFFF`, force `next_base=FFFFFFF0` → grant with base FFFFFFF0, `work_len=16`, then `range_done` is set and no further grants occur.
- Abort with hit: `abort` and `hit_valid[2]` (counter 0x99) on the same cycle → `found=1`, `result=0x99`. A plain abort gives `found=0` and `exhausted=0`.
